// File: rtl/serial_frame_tx_if.sv
// Byte handshake and serial-line bundle for serial_frame_tx.
// master = byte producer / line observer, slave = the transmitter.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              par_inj;
  logic              ready;
  logic              serial_data;
  logic              busy;
  logic              frame_done;

  modport master (
    output data, valid, par_inj,
    input  ready, serial_data, busy, frame_done
  );

  modport slave (
    input  data, valid, par_inj,
    output ready, serial_data, busy, frame_done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, even parity, stop, idle gap.
// Define SER_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO in front of the FSM.
module serial_frame_tx #(
  parameter int   DATA_W       = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic START_LVL    = 1'b1,
  parameter int   GAP_BITS     = 2,
  parameter int   FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W + 1);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);

  if (DATA_W < 1 || CLKS_PER_BIT < 1 || GAP_BITS < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("serial_frame_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  // Entry layout: {par_inj, data}
  typedef logic [DATA_W:0] entry_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     idx_q;
  logic [GW-1:0]     gap_q;
  logic [DATA_W-1:0] sreg_q;
  logic              par_q;
  logic              line_q, line_d;
  logic              busy_q;
  logic              done_q;

  logic              tick;
  logic              last_bit;
  logic              last_gap;
  logic              load;
  logic              avail;
  logic              ready_c;
  entry_t            head;

`ifdef SER_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  entry_t      mem [FIFO_DEPTH];
  logic        empty, full, push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ready_c = !full && !rst;
  assign push    = bus.valid && ready_c;
  // An empty FIFO forwards the incoming entry so the IDLE latency stays one edge.
  assign avail   = !empty || push;
  assign head    = empty ? {bus.par_inj, bus.data} : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.par_inj, bus.data};
  end
`else
  assign ready_c = (state_q == S_IDLE) && !rst;
  assign avail   = bus.valid && ready_c;
  assign head    = {bus.par_inj, bus.data};
`endif

  assign tick     = (timer_q == '0);
  assign last_bit = (idx_q == IW'(DATA_W - 1));
  assign last_gap = (gap_q == GW'(GAP_BITS - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE:   if (avail) begin
                  state_d = S_START;
                  load    = 1'b1;
                end
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && last_bit) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_GAP;
      S_GAP:    if (tick && last_gap) begin
                  if (avail) begin
                    state_d = S_START;
                    load    = 1'b1;
                  end else begin
                    state_d = S_IDLE;
                  end
                end
      default:  state_d = S_IDLE;
    endcase
  end

  // Line level for the current state; registered below, so the pin trails the state by one clk.
  always_comb begin
    line_d = ~START_LVL;
    unique case (state_q)
      S_START:  line_d = START_LVL;
      S_DATA:   line_d = sreg_q[0];
      S_PARITY: line_d = par_q;
      default:  line_d = ~START_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sreg_q  <= '0;
      par_q   <= 1'b0;
      line_q  <= ~START_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= (tick || state_q == S_IDLE) ? T_RELOAD : timer_q - 1'b1;
      if (state_q == S_DATA && tick) idx_q <= last_bit ? '0 : idx_q + 1'b1;
      if (state_q == S_GAP && tick)  gap_q <= last_gap ? '0 : gap_q + 1'b1;
      if (load) begin
        sreg_q <= head[DATA_W-1:0];
        par_q  <= ^head;
      end else if (state_q == S_DATA && tick) begin
        sreg_q <= sreg_q >> 1;
      end
      line_q <= line_d;
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_STOP) && tick;
    end
  end

  assign bus.ready       = ready_c;
  assign bus.serial_data = line_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default instance plus a CLKS_PER_BIT=3 instance.
// Back-to-back expectations follow SER_TX_FIFO_EN when it is defined.
module tb_serial_frame_tx;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  serial_frame_tx_if #(.DATA_W(8)) bi0 ();
  serial_frame_tx_if #(.DATA_W(8)) bi3 ();

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bi0.slave)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (bi3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp_line[12] is the line after the 1st edge past the accept edge, exp_line[0] after the 13th.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic inj,
                            input logic [12:0] exp_line);
    bi0.data    = d;
    bi0.par_inj = inj;
    bi0.valid   = 1'b1;
    check({tag, ".ready_in"}, bi0.ready, 1'b1);
    step();
    bi0.valid   = 1'b0;
    bi0.par_inj = 1'b0;
    bi0.data    = 8'h00;
    check({tag, ".latency"}, bi0.serial_data, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      step();
      check($sformatf("%s.line%0d", tag, i), bi0.serial_data, exp_line[13-i]);
      check($sformatf("%s.done%0d", tag, i), bi0.frame_done, (i == 11));
      check($sformatf("%s.busy%0d", tag, i), bi0.busy, 1'b1);
`ifdef SER_TX_FIFO_EN
      check($sformatf("%s.ready%0d", tag, i), bi0.ready, 1'b1);
`else
      check($sformatf("%s.ready%0d", tag, i), bi0.ready, (i == 13));
`endif
    end
    step();
    check({tag, ".busy_end"}, bi0.busy, 1'b0);
    check({tag, ".ready_end"}, bi0.ready, 1'b1);
  endtask

  initial begin
    rst         = 1'b1;
    bi0.data    = 8'h00;
    bi0.valid   = 1'b0;
    bi0.par_inj = 1'b0;
    bi3.data    = 8'h00;
    bi3.valid   = 1'b0;
    bi3.par_inj = 1'b0;

    // Reset held three cycles
    step(); step(); step();
    check("rst.line",  bi0.serial_data, 1'b0);
    check("rst.busy",  bi0.busy,        1'b0);
    check("rst.done",  bi0.frame_done,  1'b0);
    check("rst.ready", bi0.ready,       1'b0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", bi0.ready, 1'b1);

    // start, d0..d7, parity, stop, gap, gap
    send_frame("a5",     8'hA5, 1'b0, 13'b1_10100101_0_0_00);
    send_frame("07",     8'h07, 1'b0, 13'b1_11100000_1_0_00);
    send_frame("07_inj", 8'h07, 1'b1, 13'b1_11100000_0_0_00);

`ifdef SER_TX_FIFO_EN
    // Five pushes on consecutive cycles; start bits 13 cycles apart
    for (int k = 0; k < 5; k++) begin
      bi0.data  = 8'(k + 1);
      bi0.valid = 1'b1;
      check($sformatf("b2b.ready_push%0d", k), bi0.ready, 1'b1);
      step();
    end
    bi0.valid = 1'b0;
    check("b2b.full", bi0.ready, 1'b0);
    for (int c = 5; c <= 66; c++) begin
      int f;
      int r;
      logic [7:0] v;
      step();
      f = c / 13;
      r = c % 13;
      v = 8'(f + 1);
      if (c == 13) check("b2b.ready_after_pop", bi0.ready, 1'b1);
      if (c < 65) begin
        if (r == 1) check($sformatf("b2b.start%0d", f), bi0.serial_data, 1'b1);
        if (r == 0) check($sformatf("b2b.gap%0d", f), bi0.serial_data, 1'b0);
        if (r == 2) check($sformatf("b2b.d0_%0d", f), bi0.serial_data, v[0]);
        if (r == 3) check($sformatf("b2b.d1_%0d", f), bi0.serial_data, v[1]);
        check($sformatf("b2b.done_c%0d", c), bi0.frame_done, (r == 11));
      end
    end
    check("b2b.busy_end", bi0.busy, 1'b0);
`else
    // valid held high: second accept waits for IDLE, so start bits land 14 cycles apart
    bi0.data  = 8'h01;
    bi0.valid = 1'b1;
    step();
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 1)  check("hold.start1", bi0.serial_data, 1'b1);
      if (c == 2)  check("hold.d0",     bi0.serial_data, 1'b1);
      if (c == 5)  check("hold.ready_busy", bi0.ready, 1'b0);
      if (c == 13) check("hold.ready_idle", bi0.ready, 1'b1);
      if (c == 14) check("hold.idle14", bi0.serial_data, 1'b0);
      if (c == 15) check("hold.start2", bi0.serial_data, 1'b1);
    end
    bi0.valid = 1'b0;
    for (int c = 16; c <= 28; c++) step();
    check("hold.busy_end", bi0.busy, 1'b0);
`endif

    // CLKS_PER_BIT=3, 0x80: start 1-3, bit7 25-27, parity 28-30, done on 33, period 39
    bi3.data  = 8'h80;
    bi3.valid = 1'b1;
    step();
    bi3.valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c <= 39) begin
        check($sformatf("cpb3.line%0d", c), bi3.serial_data,
              (c <= 3) || (c >= 25 && c <= 30));
        check($sformatf("cpb3.done%0d", c), bi3.frame_done, (c == 33));
      end
      if (c == 39) check("cpb3.busy39", bi3.busy, 1'b1);
      if (c == 40) check("cpb3.busy40", bi3.busy, 1'b0);
    end

    // Reset during DATA bit 4 of 0xFF; pending entries must not survive
    bi0.data  = 8'hFF;
    bi0.valid = 1'b1;
    step();
`ifdef SER_TX_FIFO_EN
    bi0.data = 8'h11;
    step();
    bi0.data = 8'h22;
    step();
    bi0.valid = 1'b0;
    for (int c = 3; c <= 6; c++) step();
`else
    bi0.valid = 1'b0;
    for (int c = 1; c <= 6; c++) step();
`endif
    check("mid.d4_high", bi0.serial_data, 1'b1);
    rst = 1'b1;
    step();
    check("mid.line",  bi0.serial_data, 1'b0);
    check("mid.busy",  bi0.busy,        1'b0);
    check("mid.done",  bi0.frame_done,  1'b0);
    check("mid.ready", bi0.ready,       1'b0);
    rst = 1'b0;
    #1;
    check("mid.ready_after", bi0.ready, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      step();
      check($sformatf("mid.quiet_line%0d", c), bi0.serial_data, 1'b0);
      check($sformatf("mid.quiet_busy%0d", c), bi0.busy,        1'b0);
    end
    send_frame("3c", 8'h3C, 1'b0, 13'b1_00111100_0_0_00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
